// File: rtl/ddma_rx_engine_if.sv
// Bundle of the router receive port, local memory write port and the
// software command/status signals of the receive DMA engine.
interface ddma_rx_engine_if #(
  parameter int FLIT_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  // router side
  logic                  rx_i;
  logic [FLIT_WIDTH-1:0] data_i;
  logic                  credit_o;
  // memory side
  logic                  mem_enable_o;
  logic                  mem_wb_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [FLIT_WIDTH-1:0] mem_data_o;
  logic                  mem_stall_i;
  // software side
  logic                  cmd_in;
  logic [ADDR_WIDTH-1:0] addr_in;
  logic [ADDR_WIDTH-1:0] nbytes_in;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH-1:0] nbytes_o;
  logic                  overflow_o;

  // engine side
  modport slave (
    input  rx_i, data_i, mem_stall_i, cmd_in, addr_in, nbytes_in,
    output credit_o, mem_enable_o, mem_wb_o, mem_addr_o, mem_data_o,
           busy_o, done_o, nbytes_o, overflow_o
  );

  // environment side (router, memory and software driving the engine)
  modport master (
    output rx_i, data_i, mem_stall_i, cmd_in, addr_in, nbytes_in,
    input  credit_o, mem_enable_o, mem_wb_o, mem_addr_o, mem_data_o,
           busy_o, done_o, nbytes_o, overflow_o
  );
endinterface

// File: rtl/ddma_rx_engine.sv
// Receive DMA engine: once armed with a buffer base/capacity it accepts one
// packet (header, size, N payload flits) from the router and writes it word
// by word into local memory through a one-entry registered write stage.
// Flits beyond the buffer capacity are drained without being written.
module ddma_rx_engine #(
  parameter int FLIT_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  ddma_rx_engine_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_SIZE,
    S_PAYLOAD,
    S_DONE
  } state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [ADDR_WIDTH-1:0] r_cap;
  logic [ADDR_WIDTH-1:0] r_nbytes;     // byte offset of the next flit
  logic                  r_overflow;
  logic [FLIT_WIDTH-1:0] r_remaining;  // payload flits still expected
  logic                  r_done;

  // registered memory write stage
  logic                  r_wr_valid;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [FLIT_WIDTH-1:0] r_wr_data;

  logic                  w_rx_state;
  logic                  w_credit;
  logic                  w_xfer;
  logic [ADDR_WIDTH:0]   w_end_off;
  logic                  w_fits;
  logic [ADDR_WIDTH-1:0] w_wr_addr;

  // A flit may be taken only while receiving and while the write stage can
  // move; a stalled write blocks everything behind it.
  assign w_rx_state = (r_state == S_HDR) || (r_state == S_SIZE) ||
                      (r_state == S_PAYLOAD);
  assign w_credit   = w_rx_state && !bus.mem_stall_i &&
                      !(r_wr_valid && bus.mem_stall_i);
  assign w_xfer     = bus.rx_i && w_credit;

  // Capacity test done one bit wider so offset+4 cannot wrap past the check.
  assign w_end_off  = {1'b0, r_nbytes} + (ADDR_WIDTH+1)'(4);
  assign w_fits     = w_end_off <= {1'b0, r_cap};
  // Memory address wraps naturally at ADDR_WIDTH bits.
  assign w_wr_addr  = r_base + r_nbytes;

  // Write stage: load on an in-capacity transfer, retire when memory accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
    end else if (w_xfer && w_fits) begin
      r_wr_valid <= 1'b1;
      r_wr_addr  <= w_wr_addr;
      r_wr_data  <= bus.data_i;
    end else if (!bus.mem_stall_i) begin
      r_wr_valid <= 1'b0;
    end
  end

  // Buffer descriptor, byte counter and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base     <= '0;
      r_cap      <= '0;
      r_nbytes   <= '0;
      r_overflow <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.cmd_in) begin
        r_base     <= bus.addr_in;
        r_cap      <= bus.nbytes_in;
        r_nbytes   <= '0;
        r_overflow <= 1'b0;
      end
    end else if (w_xfer) begin
      r_nbytes <= r_nbytes + ADDR_WIDTH'(4);
      if (!w_fits) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Packet sequencing; DONE first waits for the last write to retire, then
  // raises done for one cycle before returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_remaining <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.cmd_in) begin
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_xfer) begin
            r_state <= S_SIZE;
          end
        end
        S_SIZE: begin
          if (w_xfer) begin
            r_remaining <= bus.data_i;
            if (bus.data_i == '0) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            r_remaining <= r_remaining - FLIT_WIDTH'(1);
            if (r_remaining == FLIT_WIDTH'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          if (r_done) begin
            r_done  <= 1'b0;
            r_state <= S_IDLE;
          end else if (!r_wr_valid || !bus.mem_stall_i) begin
            r_done <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.credit_o     = w_credit;
  assign bus.mem_enable_o = r_wr_valid;
  assign bus.mem_wb_o     = r_wr_valid;
  assign bus.mem_addr_o   = r_wr_addr;
  assign bus.mem_data_o   = r_wr_data;
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.done_o       = r_done;
  assign bus.nbytes_o     = r_nbytes;
  assign bus.overflow_o   = r_overflow;

endmodule

// File: doc/ddma_rx_engine.md
# ddma_rx_engine

Receive-side DMA engine for a node's local router port, the counterpart of the transmit DDMA. Once software arms it with a buffer base address and capacity, it accepts one packet of flits from the router, stores the packet word-by-word into local memory, and reports completion. Flow control back to the router uses the port's credit signal.

## Interface
- FLIT_WIDTH, 32: flit and memory data width.
- ADDR_WIDTH, 32: memory address width and width of the byte counters.
- clock  in  1  single clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_i  in  1  router flit valid.
- data_i  in  FLIT_WIDTH  router flit.
- credit_o  out  1  engine can take a flit this cycle. A flit transfers on rx_i && credit_o.
- mem_enable_o  out  1  memory access strobe.
- mem_wb_o  out  1  memory write-back (write enable).
- mem_addr_o  out  ADDR_WIDTH  byte address of the write.
- mem_data_o  out  FLIT_WIDTH  write data.
- mem_stall_i  in  1  memory cannot take a write this cycle.
- cmd_in  in  1  arm pulse; sampled only in IDLE.
- addr_in  in  ADDR_WIDTH  buffer base byte address (word aligned).
- nbytes_in  in  ADDR_WIDTH  buffer capacity in bytes.
- busy_o  out  1  armed or packet in progress.
- done_o  out  1  one-cycle completion pulse.
- nbytes_o  out  ADDR_WIDTH  bytes received in last/current packet (header and size flits included).
- overflow_o  out  1  last packet exceeded capacity; sticky until next arm.

## Operation
- States: IDLE, HDR, SIZE, PAYLOAD, DONE.
- IDLE: credit_o=0. If cmd_in=1, latch addr_in and nbytes_in, clear nbytes_o and overflow_o, then go to HDR.
- HDR: on transfer, write the header flit to base+0, then go to SIZE.
- SIZE: on transfer, write the size flit to base+4 and latch its value as the payload flit count N (a 32-bit word count; 8192 bytes gives N=2048).
  - N=0: go to DONE.
  - Otherwise: go to PAYLOAD with the remaining count set to N.
- PAYLOAD: the k-th payload flit (k from 0) goes to base+8+4k. Decrement the remaining count on each transfer; the last transfer (remaining=1) goes to DONE.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- busy_o=1 in HDR, SIZE, PAYLOAD and DONE.
- Each transfer adds 4 to nbytes_o, whether or not the flit is written.
- Capacity check: a flit whose byte offset + 4 exceeds the capacity is not written. It is still accepted (drained) so the router never blocks, and overflow_o is set.
- credit_o = (state ∈ {HDR, SIZE, PAYLOAD}) && !mem_stall_i && !(write register full && mem_stall_i).
- cmd_in outside IDLE is ignored and does not change the latched values.
- rx_i=1 while in IDLE or DONE is not accepted (credit_o=0); the flit stays with the router.
- Address arithmetic wraps modulo 2^ADDR_WIDTH. No error is flagged.

## Timing
- Reset (asynchronous assert, synchronous release): state=IDLE; credit_o, mem_enable_o, mem_wb_o, busy_o, done_o and overflow_o are 0; mem_addr_o, mem_data_o and nbytes_o are 0. Reset mid-packet drops the fragment. No done_o pulse is issued.
- Arm latency: cmd_in at edge t gives busy_o=1 and credit_o=1 from t+1 (absent stall).
- Write path is a one-entry registered stage: a transfer at edge t drives mem_enable_o=mem_wb_o=1 with the matching addr/data during cycle t+1.
- Back-to-back transfers give one write per cycle. Throughput is 1 flit/cycle.
- Stall while a write is presented: the write outputs hold unchanged and credit_o=0 until mem_stall_i=0. The write completes in the first cycle with mem_stall_i=0.
- done_o asserts the cycle after the last flit's write is presented and accepted. Every memory write of the packet therefore completes before done_o.
- Minimum packet (header plus N=0): arm at t, flits at t+1 and t+2, done_o at t+4, IDLE at t+5.

## Test plan
- 8192-byte packet, base 0x0, capacity 8200: header 0x00020001, size 2048, payload = counter values. Required: 2050 writes, last at 0x2004; done_o pulses once; nbytes_o=8200; overflow_o=0.
- Size 0: arm with base 0x100; send header and size 0. Required: writes at 0x100 and 0x104 only; done_o pulses; nbytes_o=8.
- Overflow: capacity 16 with N=6. Required: writes at base+0…+12 only; all 8 flits accepted; overflow_o=1; nbytes_o=32; done_o pulses.
- Memory stall: hold mem_stall_i=1 for 5 cycles mid-payload. Required: write outputs constant and credit_o=0 during the stall; no flit lost or duplicated; addresses stay contiguous.
- cmd_in with addr_in 0x400 during PAYLOAD: ignored; writes continue at the original base.
- Reset asserted after 10 payload flits: all outputs 0 immediately; no done_o; a re-arm then receives a full packet correctly.
